// File: rtl/mdu_sequencer_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Package : libAlu                                                      |
// | Purpose : Shared ALU/MDU definitions: the MDU sequencer state type,   |
// |           divider iteration count, the ALU operation codes the MDU    |
// |           reacts to, and a small absolute-value helper.               |
// | Ports   : none (package)                                              |
// | Config  : mduAbs is only referenced when MDU_SIGNED_EN is defined.    |
// | Revision: 1.0  initial release                                        |
// +----------------------------------------------------------------------+
package libAlu;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MULT = 2'd1,
    DIV  = 2'd2
  } mduState_t;

  localparam int MDU_DIV_CYCLES = 32;

  localparam logic [3:0] ALU_MULT = 4'h8;
  localparam logic [3:0] ALU_DIV  = 4'h9;

  // Magnitude of a two's-complement word; 0x8000_0000 maps to itself,
  // which is the correct unsigned magnitude.
  function automatic logic [31:0] mduAbs(input logic [31:0] value);
    return value[31] ? (~value + 32'd1) : value;
  endfunction

endpackage

`default_nettype wire

// File: rtl/mdu_sequencer_div_iter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : div_iter                                                    |
// | Purpose : Restoring shift/subtract divider datapath, one quotient     |
// |           bit per step.                                               |
// | Ports   : clock, reset (async active-low)                             |
// |           load      - capture dividend/divisor, clear partial rem     |
// |           step      - commit one iteration                            |
// |           dividend  - 32-bit dividend (unsigned magnitude)            |
// |           divisor   - 32-bit divisor  (unsigned magnitude)            |
// |           quotient  - quotient as it stands AFTER the current step    |
// |           remainder - remainder as it stands AFTER the current step   |
// | Revision: 1.0  initial release                                        |
// +----------------------------------------------------------------------+
module div_iter (
  input  logic        clock,
  input  logic        reset,
  input  logic        load,
  input  logic        step,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  output logic [31:0] quotient,
  output logic [31:0] remainder
);

  // r_quo starts as the dividend; each step shifts its MSB into the partial
  // remainder and shifts a quotient bit in at the bottom.
  logic [31:0] r_rem;
  logic [31:0] r_quo;
  logic [31:0] r_div;

  logic [32:0] w_trial;
  logic        w_fit;
  logic [31:0] w_diff;
  logic [31:0] w_nextRem;
  logic [31:0] w_nextQuo;

  assign w_trial   = {r_rem, r_quo[31]};
  assign w_fit     = w_trial >= {1'b0, r_div};
  // When the trial fits, the true difference is below 2^32, so the
  // wrapped 32-bit subtraction is exact.
  assign w_diff    = w_trial[31:0] - r_div;
  assign w_nextRem = w_fit ? w_diff : w_trial[31:0];
  assign w_nextQuo = {r_quo[30:0], w_fit};

  // Exposing the post-step values lets the sequencer capture the final
  // result on the same edge that commits the last iteration.
  assign quotient  = w_nextQuo;
  assign remainder = w_nextRem;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_rem <= '0;
      r_quo <= '0;
      r_div <= '0;
    end else if (load) begin
      r_rem <= '0;
      r_quo <= dividend;
      r_div <= divisor;
    end else if (step) begin
      r_rem <= w_nextRem;
      r_quo <= w_nextQuo;
    end
  end

endmodule

`default_nettype wire

// File: rtl/mdu_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : mdu_sequencer                                               |
// | Purpose : Multiply/divide unit sequencer. Multiply completes after    |
// |           MULT_CYCLES (1..8) cycles, divide after 32 iterations.      |
// |           Results land in architectural HI/LO registers.             |
// | Ports   : clock, reset (async active-low)                             |
// |           start/control/numberA/numberB - operation request           |
// |           flush      - abort in-flight op, no done, HI/LO kept        |
// |           busy       - operation in flight                            |
// |           done       - one-cycle completion pulse                     |
// |           divByZero  - with done when the divisor was zero            |
// |           outputHiLo - [0] = HI, [1] = LO                             |
// |           signedOp   - two's-complement mode (MDU_SIGNED_EN only)     |
// | Config  : MDU_SIGNED_EN adds signedOp and signed arithmetic.          |
// | Revision: 1.0  initial release                                        |
// +----------------------------------------------------------------------+
module mdu_sequencer #(
  parameter int MULT_CYCLES = 4
) (
  input  logic             clock,
  input  logic             reset,
`ifdef MDU_SIGNED_EN
  input  logic             signedOp,
`endif
  input  logic             start,
  input  logic             flush,
  input  logic [3:0]       control,
  input  logic [31:0]      numberA,
  input  logic [31:0]      numberB,
  output logic             busy,
  output logic             done,
  output logic             divByZero,
  output logic [1:0][31:0] outputHiLo
);

  import libAlu::*;

  localparam logic [4:0] C_MULT_LAST = 5'(MULT_CYCLES - 1);
  localparam logic [4:0] C_DIV_LAST  = 5'(MDU_DIV_CYCLES - 1);

  mduState_t   r_state;
  logic [4:0]  r_count;
  logic [31:0] r_opA;
  logic [31:0] r_opB;
  logic        r_divZero;

  logic        w_isMult;
  logic        w_isDiv;
  logic        w_accept;
  logic        w_multLast;
  logic        w_divLast;
  logic        w_write;
  logic [31:0] w_loadA;
  logic [31:0] w_loadB;
  logic [63:0] w_extA;
  logic [63:0] w_extB;
  logic [63:0] w_product;
  logic        w_negQuo;
  logic        w_negRem;
  logic [31:0] w_iterQuo;
  logic [31:0] w_iterRem;
  logic [31:0] w_resHi;
  logic [31:0] w_resLo;

  assign w_isMult   = (control == ALU_MULT);
  assign w_isDiv    = (control == ALU_DIV);
  // flush overrides start; unknown codes are ignored entirely.
  assign w_accept   = (r_state == IDLE) && start && !flush && (w_isMult || w_isDiv);
  assign w_multLast = (r_state == MULT) && (r_count == C_MULT_LAST);
  assign w_divLast  = (r_state == DIV)  && (r_count == C_DIV_LAST);
  assign w_write    = (w_multLast || w_divLast) && !flush;

  assign busy = (r_state != IDLE);

`ifdef MDU_SIGNED_EN
  logic r_signed;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_signed <= 1'b0;
    end else if (w_accept) begin
      r_signed <= signedOp;
    end
  end

  // Divider works on magnitudes; signs are restored on the write edge.
  assign w_loadA  = signedOp ? mduAbs(numberA) : numberA;
  assign w_loadB  = signedOp ? mduAbs(numberB) : numberB;
  // Low 64 bits of the sign-extended product equal the signed product.
  assign w_extA   = r_signed ? {{32{r_opA[31]}}, r_opA} : {32'd0, r_opA};
  assign w_extB   = r_signed ? {{32{r_opB[31]}}, r_opB} : {32'd0, r_opB};
  assign w_negQuo = r_signed && (r_opA[31] ^ r_opB[31]);
  assign w_negRem = r_signed && r_opA[31];
`else
  assign w_loadA  = numberA;
  assign w_loadB  = numberB;
  assign w_extA   = {32'd0, r_opA};
  assign w_extB   = {32'd0, r_opB};
  assign w_negQuo = 1'b0;
  assign w_negRem = 1'b0;
`endif

  assign w_product = w_extA * w_extB;

  div_iter u_div_iter (
    .clock     (clock),
    .reset     (reset),
    .load      (w_accept && w_isDiv),
    .step      (r_state == DIV),
    .dividend  (w_loadA),
    .divisor   (w_loadB),
    .quotient  (w_iterQuo),
    .remainder (w_iterRem)
  );

  always_comb begin
    w_resHi = w_product[63:32];
    w_resLo = w_product[31:0];
    if (!w_multLast) begin
      if (r_divZero) begin
        w_resHi = r_opA;
        w_resLo = 32'hFFFF_FFFF;
      end else begin
        w_resHi = w_negRem ? (~w_iterRem + 32'd1) : w_iterRem;
        w_resLo = w_negQuo ? (~w_iterQuo + 32'd1) : w_iterQuo;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state    <= IDLE;
      r_count    <= '0;
      r_opA      <= '0;
      r_opB      <= '0;
      r_divZero  <= 1'b0;
      done       <= 1'b0;
      divByZero  <= 1'b0;
      outputHiLo <= '0;
    end else begin
      done      <= 1'b0;
      divByZero <= 1'b0;
      if (flush) begin
        r_state <= IDLE;
      end else begin
        case (r_state)
          IDLE: begin
            if (w_accept) begin
              r_state   <= w_isMult ? MULT : DIV;
              r_count   <= '0;
              r_opA     <= numberA;
              r_opB     <= numberB;
              r_divZero <= (numberB == 32'd0);
            end
          end
          MULT, DIV: begin
            if (w_write) begin
              r_state       <= IDLE;
              outputHiLo[0] <= w_resHi;
              outputHiLo[1] <= w_resLo;
              done          <= 1'b1;
              divByZero     <= w_divLast && r_divZero;
            end else begin
              r_count <= r_count + 5'd1;
            end
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

endmodule

`default_nettype wire

// File: doc/mdu_sequencer.md
MDU_SEQUENCER -- requirements
Module: mdu_sequencer

Interface
REQ-001 The block SHALL have one clock, `clock`; reset `reset` SHALL be asynchronous and active-low.
REQ-002 Parameter MULT_CYCLES, default 4: the number of cycles from accepted start to done for a multiply; the legal range SHALL be 1..8.
REQ-003 Ports (name, direction, width, meaning):
- clock  in  1  rising-edge clock.
- reset  in  1  async active-low reset.
- start  in  1  request; sampled on the rising edge only.
- flush  in  1  abort of any in-flight operation.
- control  in  4  libAlu code; only ALU_MULT and ALU_DIV are acted on.
- numberA  in  32  operand A (multiplicand or dividend).
- numberB  in  32  operand B (multiplier or divisor).
- busy  out  1  operation in flight.
- done  out  1  one-cycle completion pulse.
- divByZero  out  1  high with done when the divisor was 0.
- outputHiLo  out  32x2  index [0] = HI, index [1] = LO; architectural registers.

Function
REQ-004 The FSM SHALL have three states: IDLE, MULT and DIV.
REQ-005 In IDLE, start=1 with control=ALU_MULT SHALL, on that edge (E0), register the operands and enter MULT.
REQ-006 In IDLE, start=1 with control=ALU_DIV SHALL, on E0, register the operands and enter DIV.
REQ-007 In IDLE, start=1 with any other control SHALL be ignored; no state, flag or register change.
REQ-008 A start asserted while busy=1 SHALL be ignored and never queued.
REQ-009 Multiply: {HI,LO} SHALL equal the full 64-bit product, written on edge E0+MULT_CYCLES.
REQ-010 Divide: the restoring divider SHALL process one quotient bit per cycle over exactly 32 iteration cycles.
REQ-011 Divide: LO SHALL receive the quotient and HI the remainder, written on edge E0+32.
REQ-012 busy SHALL be 1 from E0 up to the result-write edge, and 0 in the done cycle.
REQ-013 done SHALL be 1 for exactly the one cycle following the result-write edge; the FSM SHALL be back in IDLE in that cycle.
REQ-014 A start in the done cycle SHALL be accepted, giving back-to-back operations with no bubble.
REQ-015 Divisor 0: the block SHALL produce HI=numberA, LO=32'hFFFF_FFFF, divByZero=1 for the done cycle only, with unchanged 33-cycle timing.
REQ-016 flush=1 SHALL return the FSM to IDLE on the next edge, keep HI/LO unchanged and suppress done.
REQ-017 flush and start asserted in the same cycle: flush SHALL win and start SHALL be dropped.
REQ-018 outputHiLo SHALL change only on a result-write edge or on reset, and SHALL be stable otherwise, including while busy.
REQ-019 Default arithmetic SHALL be unsigned; results SHALL be exactly 32 bits per half, with no saturation.

Reset
REQ-020 Asserting reset SHALL immediately force the FSM to IDLE and outputHiLo[0], outputHiLo[1], busy, done and divByZero to 0.
REQ-021 Reset mid-operation SHALL discard that operation; no done follows reset release.
REQ-022 The first start SHALL be accepted on the first rising edge after reset deasserts.

Configuration
REQ-023 With macro MDU_SIGNED_EN defined, the block SHALL add input port `signedOp` (1 bit), registered on E0.
REQ-024 With MDU_SIGNED_EN defined and signedOp=1, operands SHALL be handled as two's complement: the product is signed, the quotient truncates toward zero and the remainder takes the dividend's sign. Latency SHALL be unchanged, with sign correction folded into the result-write edge.
REQ-025 Without MDU_SIGNED_EN, the port and the sign logic SHALL be absent and all behaviour SHALL be unsigned.

Structure
REQ-026 Package libAlu SHALL hold the typedef mduState_t {IDLE, MULT, DIV}, the constant MDU_DIV_CYCLES = 32, and the existing ALU_MULT and ALU_DIV codes.
REQ-027 The shift/subtract datapath SHALL be sub-module `div_iter`, with ports load, step, dividend, divisor, quotient and remainder. The FSM, counter, HI/LO registers and multiplier pipeline SHALL remain in mdu_sequencer.

Verification
REQ-028 MULT 0x0001_0000 x 0x0001_0000, MULT_CYCLES=4 -> done 4 cycles after E0; HI=0x1, LO=0x0.
REQ-029 DIV 100 / 7 -> busy for 32 cycles, done at E0+32; LO=14, HI=2, divByZero=0.
REQ-030 DIV 0xDEAD_BEEF / 0 -> HI=0xDEAD_BEEF, LO=0xFFFF_FFFF, divByZero pulses with done.
REQ-031 Start a DIV, assert flush at cycle 10, then start MULT 3 x 5 -> no done from the DIV; HI/LO unchanged until the MULT writes HI=0, LO=15.
REQ-032 Reset asserted mid-MULT with HI/LO nonzero -> all outputs 0 asynchronously; start in the done cycle of a prior op is accepted (REQ-014 check).
REQ-033 With MDU_SIGNED_EN, DIV -7 / 2, signedOp=1 -> LO=0xFFFF_FFFD (-3), HI=0xFFFF_FFFF (-1).
